// File: rtl/xm_pkg.sv
// Shared definitions for the memory-port arbiter: FSM states, requester IDs,
// access direction encoding and byte-lane patterns.
package xm_pkg;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    // Requester identifiers (also the encoding of the grant / lastGrant regs)
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

    // Access direction
    localparam logic MEM_RD = 1'b0;
    localparam logic MEM_WR = 1'b1;

    // Byte-lane enables, bit 0 = low byte, bit 1 = high byte
    localparam logic [1:0] LANE_LO   = 2'b01;
    localparam logic [1:0] LANE_HI   = 2'b10;
    localparam logic [1:0] LANE_WORD = 2'b11;

    // Lane pattern for an access: word ops use both lanes, byte ops pick the
    // lane addressed by bit 0 of the byte address.
    function automatic logic [1:0] lane_sel(input logic byte_op, input logic a0);
        if (!byte_op)
            return LANE_WORD;
        return a0 ? LANE_HI : LANE_LO;
    endfunction

endpackage

// File: rtl/xm_mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals of the arbiter.
// slave  = the arbiter's view (takes requests, drives memory strobes)
// master = the environment's view (requesters plus the memory itself)
interface xm_mem_arbiter_if #(
    parameter int WORD = 16,
    parameter int ADR  = 16
);
    // CPU controller requester
    logic            cpuEn_i;
    logic            cpuRW_i;
    logic            cpuByte_i;
    logic [ADR-1:0]  cpuAdr_i;
    logic [WORD-1:0] cpuData_i;
    logic [WORD-1:0] cpuData_o;
    logic            cpuBusy_o;

    // Secondary (DMA / debug) requester
    logic            dmaEn_i;
    logic            dmaRW_i;
    logic            dmaByte_i;
    logic [ADR-1:0]  dmaAdr_i;
    logic [WORD-1:0] dmaData_i;
    logic [WORD-1:0] dmaData_o;
    logic            dmaBusy_o;

    // Memory port
    logic            ramEn_o;
    logic            ramWr_o;
    logic [1:0]      ramLane_o;
    logic [ADR-1:0]  ramAdr_o;
    logic [WORD-1:0] ramData_o;
    logic [WORD-1:0] ramData_i;

    modport slave (
        input  cpuEn_i, cpuRW_i, cpuByte_i, cpuAdr_i, cpuData_i,
        output cpuData_o, cpuBusy_o,
        input  dmaEn_i, dmaRW_i, dmaByte_i, dmaAdr_i, dmaData_i,
        output dmaData_o, dmaBusy_o,
        output ramEn_o, ramWr_o, ramLane_o, ramAdr_o, ramData_o,
        input  ramData_i
    );

    modport master (
        output cpuEn_i, cpuRW_i, cpuByte_i, cpuAdr_i, cpuData_i,
        input  cpuData_o, cpuBusy_o,
        output dmaEn_i, dmaRW_i, dmaByte_i, dmaAdr_i, dmaData_i,
        input  dmaData_o, dmaBusy_o,
        input  ramEn_o, ramWr_o, ramLane_o, ramAdr_o, ramData_o,
        output ramData_i
    );

endinterface

// File: rtl/xm_mem_req_slot.sv
// One-deep request slot for a single requester. A request pulse is taken only
// while the slot is empty; the slot then stays occupied (busy) until the
// arbiter signals completion with clr.
module xm_mem_req_slot #(
    parameter int WORD = 16,
    parameter int ADR  = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            rw,
    input  logic            byte_op,
    input  logic [ADR-1:0]  adr,
    input  logic [WORD-1:0] data,
    input  logic            clr,
    output logic            busy,
    output logic            rw_q,
    output logic            byte_q,
    output logic [ADR-1:0]  adr_q,
    output logic [WORD-1:0] data_q
);

    // Latch a request into an empty slot; release the slot on completion.
    // clr only arrives while busy, so it never races with an accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy   <= 1'b0;
            rw_q   <= 1'b0;
            byte_q <= 1'b0;
            adr_q  <= '0;
            data_q <= '0;
        end else if (clr) begin
            busy <= 1'b0;
        end else if (en && !busy) begin
            busy   <= 1'b1;
            rw_q   <= rw;
            byte_q <= byte_op;
            adr_q  <= adr;
            data_q <= data;
        end
    end

endmodule

// File: rtl/xm_mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between the CPU
// controller and a DMA/debug requester. Each requester owns a one-deep slot;
// the FSM grants a pending slot, holds the memory strobes for WAIT+1 cycles,
// returns read data (byte-extracted for byte reads) and releases the slot.
module xm_mem_arbiter
    import xm_pkg::*;
#(
    parameter int WORD = 16,
    parameter int ADR  = 16,
    parameter int WAIT = 2
) (
    input  logic              clk_i,
    input  logic              arst_i,
    xm_mem_arbiter_if.slave   bus
);

    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    // Slot contents
    logic            cpu_busy, cpu_rw, cpu_byte;
    logic [ADR-1:0]  cpu_adr;
    logic [WORD-1:0] cpu_wdata;
    logic            dma_busy, dma_rw, dma_byte;
    logic [ADR-1:0]  dma_adr;
    logic [WORD-1:0] dma_wdata;
    logic            cpu_clr, dma_clr;

    // Arbiter state
    arb_state_t      state;
    logic [3:0]      cnt;
    logic            gnt;
    logic            last_gnt;

    // Registered outputs
    logic            ram_en, ram_wr;
    logic [1:0]      ram_lane;
    logic [ADR-1:0]  ram_adr;
    logic [WORD-1:0] ram_wdata;
    logic [WORD-1:0] cpu_rdata, dma_rdata;

    // Grant selection and request mux
    logic            any_pend;
    logic            nxt_gnt;
    logic            sel_rw, sel_byte;
    logic [ADR-1:0]  sel_adr;
    logic [WORD-1:0] sel_data;
    logic            cur_rw, cur_byte, cur_a0;
    logic [WORD-1:0] rd_word;

    xm_mem_req_slot #(.WORD(WORD), .ADR(ADR)) u_cpu_slot (
        .clk     (clk_i),
        .rst     (arst_i),
        .en      (bus.cpuEn_i),
        .rw      (bus.cpuRW_i),
        .byte_op (bus.cpuByte_i),
        .adr     (bus.cpuAdr_i),
        .data    (bus.cpuData_i),
        .clr     (cpu_clr),
        .busy    (cpu_busy),
        .rw_q    (cpu_rw),
        .byte_q  (cpu_byte),
        .adr_q   (cpu_adr),
        .data_q  (cpu_wdata)
    );

    xm_mem_req_slot #(.WORD(WORD), .ADR(ADR)) u_dma_slot (
        .clk     (clk_i),
        .rst     (arst_i),
        .en      (bus.dmaEn_i),
        .rw      (bus.dmaRW_i),
        .byte_op (bus.dmaByte_i),
        .adr     (bus.dmaAdr_i),
        .data    (bus.dmaData_i),
        .clr     (dma_clr),
        .busy    (dma_busy),
        .rw_q    (dma_rw),
        .byte_q  (dma_byte),
        .adr_q   (dma_adr),
        .data_q  (dma_wdata)
    );

    // Pick the next grant: on contention the requester not served last wins.
    always_comb begin
        any_pend = cpu_busy | dma_busy;
        if (cpu_busy && dma_busy)
            nxt_gnt = (last_gnt == REQ_CPU) ? REQ_DMA : REQ_CPU;
        else
            nxt_gnt = cpu_busy ? REQ_CPU : REQ_DMA;
    end

    // Steer the chosen slot onto the launch path, and the granted slot onto
    // the read-return path. Slot contents stay stable until release.
    always_comb begin
        sel_rw   = (nxt_gnt == REQ_CPU) ? cpu_rw    : dma_rw;
        sel_byte = (nxt_gnt == REQ_CPU) ? cpu_byte  : dma_byte;
        sel_adr  = (nxt_gnt == REQ_CPU) ? cpu_adr   : dma_adr;
        sel_data = (nxt_gnt == REQ_CPU) ? cpu_wdata : dma_wdata;
        cur_rw   = (gnt == REQ_CPU) ? cpu_rw   : dma_rw;
        cur_byte = (gnt == REQ_CPU) ? cpu_byte : dma_byte;
        cur_a0   = (gnt == REQ_CPU) ? cpu_adr[0] : dma_adr[0];
        if (cur_byte)
            rd_word = {{(WORD-8){1'b0}}, (cur_a0 ? bus.ramData_i[15:8] : bus.ramData_i[7:0])};
        else
            rd_word = bus.ramData_i;
    end

    // Release the granted slot during DONE
    assign cpu_clr = (state == DONE) && (gnt == REQ_CPU);
    assign dma_clr = (state == DONE) && (gnt == REQ_DMA);

    // Access sequencer: IDLE -> ACCESS (WAIT+1 cycles) -> DONE -> IDLE
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state     <= IDLE;
            cnt       <= '0;
            gnt       <= REQ_CPU;
            last_gnt  <= REQ_DMA;
            ram_en    <= 1'b0;
            ram_wr    <= 1'b0;
            ram_lane  <= '0;
            ram_adr   <= '0;
            ram_wdata <= '0;
            cpu_rdata <= '0;
            dma_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_pend) begin
                        gnt      <= nxt_gnt;
                        cnt      <= WAIT_CNT;
                        state    <= ACCESS;
                        ram_en   <= 1'b1;
                        ram_wr   <= (sel_rw == MEM_WR);
                        ram_lane <= lane_sel(sel_byte, sel_adr[0]);
                        ram_adr  <= {sel_adr[ADR-1:1], 1'b0};
                        // Byte writes replicate the low byte onto both halves
                        ram_wdata <= sel_byte ? {(WORD/8){sel_data[7:0]}} : sel_data;
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        state    <= DONE;
                        ram_en   <= 1'b0;
                        ram_wr   <= 1'b0;
                        ram_lane <= '0;
                        if (cur_rw == MEM_RD) begin
                            if (gnt == REQ_CPU)
                                cpu_rdata <= rd_word;
                            else
                                dma_rdata <= rd_word;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    last_gnt <= gnt;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cpuBusy_o = cpu_busy;
    assign bus.dmaBusy_o = dma_busy;
    assign bus.cpuData_o = cpu_rdata;
    assign bus.dmaData_o = dma_rdata;
    assign bus.ramEn_o   = ram_en;
    assign bus.ramWr_o   = ram_wr;
    assign bus.ramLane_o = ram_lane;
    assign bus.ramAdr_o  = ram_adr;
    assign bus.ramData_o = ram_wdata;

endmodule

// File: tb/tb_xm_mem_arbiter.sv
// Directed bench for xm_mem_arbiter: a WAIT=2 instance backed by a small
// byte-lane memory model, plus a WAIT=0 instance with a constant read word.
module tb_xm_mem_arbiter;

    logic clk;
    logic arst;

    xm_mem_arbiter_if #(.WORD(16), .ADR(16)) bus ();
    xm_mem_arbiter_if #(.WORD(16), .ADR(16)) bus0 ();

    xm_mem_arbiter #(.WORD(16), .ADR(16), .WAIT(2)) u_dut (
        .clk_i  (clk),
        .arst_i (arst),
        .bus    (bus)
    );

    xm_mem_arbiter #(.WORD(16), .ADR(16), .WAIT(0)) u_dut0 (
        .clk_i  (clk),
        .arst_i (arst),
        .bus    (bus0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model for the WAIT=2 instance: 256 words, lane-masked writes
    logic [15:0] mem [0:255];
    assign bus.ramData_i  = mem[bus.ramAdr_o[8:1]];
    assign bus0.ramData_i = 16'h1234;

    always @(posedge clk) begin
        if (bus.ramEn_o && bus.ramWr_o) begin
            if (bus.ramLane_o[0]) mem[bus.ramAdr_o[8:1]][7:0]  <= bus.ramData_o[7:0];
            if (bus.ramLane_o[1]) mem[bus.ramAdr_o[8:1]][15:8] <= bus.ramData_o[15:8];
        end
    end

    // Grant log: address presented on each rising edge of ramEn_o
    logic [15:0] grant_q [$];
    logic        en_prev = 1'b0;
    always @(negedge clk) begin
        if (bus.ramEn_o && !en_prev) grant_q.push_back(bus.ramAdr_o);
        en_prev <= bus.ramEn_o;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Single request on the WAIT=2 instance; called and returns at #1 after a
    // rising edge. Reports busy/strobe cycle counts and the first strobe beat.
    task automatic do_req(input logic who, input logic rw, input logic byt,
                          input logic [15:0] adr, input logic [15:0] data,
                          output int bc, output int ec,
                          output logic [15:0] fa, output logic [15:0] fd,
                          output logic [1:0] fl, output logic fw);
        logic b;
        logic got;
        if (who == 1'b0) begin
            bus.cpuRW_i = rw; bus.cpuByte_i = byt; bus.cpuAdr_i = adr; bus.cpuData_i = data;
            bus.cpuEn_i = 1'b1;
        end else begin
            bus.dmaRW_i = rw; bus.dmaByte_i = byt; bus.dmaAdr_i = adr; bus.dmaData_i = data;
            bus.dmaEn_i = 1'b1;
        end
        @(posedge clk); #1;
        bus.cpuEn_i = 1'b0;
        bus.dmaEn_i = 1'b0;
        bc = 0; ec = 0; got = 1'b0;
        fa = '0; fd = '0; fl = '0; fw = 1'b0;
        b = 1'b1;
        for (int i = 0; i < 40; i++) begin
            b = (who == 1'b0) ? bus.cpuBusy_o : bus.dmaBusy_o;
            if (!b) break;
            bc++;
            if (bus.ramEn_o) begin
                ec++;
                if (!got) begin
                    fa = bus.ramAdr_o; fd = bus.ramData_o; fl = bus.ramLane_o; fw = bus.ramWr_o;
                    got = 1'b1;
                end
            end
            @(posedge clk); #1;
        end
        if (b) chk("req_timeout", 32'(b), 32'd0);
    endtask

    // Simultaneous CPU and DMA reads; grant order lands in grant_q
    task automatic dual(input logic [15:0] ca, input logic [15:0] da,
                        output int cb, output int db);
        logic any;
        grant_q.delete();
        bus.cpuRW_i = 1'b0; bus.cpuByte_i = 1'b0; bus.cpuAdr_i = ca;
        bus.dmaRW_i = 1'b0; bus.dmaByte_i = 1'b0; bus.dmaAdr_i = da;
        bus.cpuEn_i = 1'b1; bus.dmaEn_i = 1'b1;
        @(posedge clk); #1;
        bus.cpuEn_i = 1'b0; bus.dmaEn_i = 1'b0;
        cb = 0; db = 0; any = 1'b1;
        for (int i = 0; i < 60; i++) begin
            any = bus.cpuBusy_o | bus.dmaBusy_o;
            if (!any) break;
            cb += int'(bus.cpuBusy_o);
            db += int'(bus.dmaBusy_o);
            @(posedge clk); #1;
        end
        if (any) chk("dual_timeout", 32'(any), 32'd0);
    endtask

    int bc, ec, cb, db;
    logic [15:0] fa, fd, g0, g1;
    logic [1:0]  fl;
    logic        fw;

    initial begin
        arst = 1'b1;
        bus.cpuEn_i = 0; bus.cpuRW_i = 0; bus.cpuByte_i = 0; bus.cpuAdr_i = 0; bus.cpuData_i = 0;
        bus.dmaEn_i = 0; bus.dmaRW_i = 0; bus.dmaByte_i = 0; bus.dmaAdr_i = 0; bus.dmaData_i = 0;
        bus0.cpuEn_i = 0; bus0.cpuRW_i = 0; bus0.cpuByte_i = 0; bus0.cpuAdr_i = 0; bus0.cpuData_i = 0;
        bus0.dmaEn_i = 0; bus0.dmaRW_i = 0; bus0.dmaByte_i = 0; bus0.dmaAdr_i = 0; bus0.dmaData_i = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ramEn",   32'(bus.ramEn_o),   32'd0);
        chk("rst_ramWr",   32'(bus.ramWr_o),   32'd0);
        chk("rst_lane",    32'(bus.ramLane_o), 32'd0);
        chk("rst_cpuBusy", 32'(bus.cpuBusy_o), 32'd0);
        chk("rst_dmaBusy", 32'(bus.dmaBusy_o), 32'd0);
        chk("rst_cpuData", 32'(bus.cpuData_o), 32'd0);
        arst = 1'b0;
        @(posedge clk); #1;

        // CPU word write then read back
        do_req(1'b0, 1'b1, 1'b0, 16'h0040, 16'hBEEF, bc, ec, fa, fd, fl, fw);
        chk("ww_busy", 32'(bc), 32'd5);
        chk("ww_en",   32'(ec), 32'd3);
        chk("ww_adr",  32'(fa), 32'h0040);
        chk("ww_lane", 32'(fl), 32'h3);
        chk("ww_data", 32'(fd), 32'hBEEF);
        chk("ww_wr",   32'(fw), 32'd1);
        do_req(1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000, bc, ec, fa, fd, fl, fw);
        chk("wr_busy", 32'(bc), 32'd5);
        chk("wr_lane", 32'(fl), 32'h3);
        chk("wr_wr",   32'(fw), 32'd0);
        chk("wr_data", 32'(bus.cpuData_o), 32'hBEEF);

        // Byte write to odd address, byte read, word read
        do_req(1'b0, 1'b1, 1'b1, 16'h0041, 16'h005A, bc, ec, fa, fd, fl, fw);
        chk("bw_lane", 32'(fl), 32'h2);
        chk("bw_adr",  32'(fa), 32'h0040);
        chk("bw_data", 32'(fd), 32'h5A5A);
        chk("bw_hold", 32'(bus.cpuData_o), 32'hBEEF);
        do_req(1'b0, 1'b0, 1'b1, 16'h0041, 16'h0000, bc, ec, fa, fd, fl, fw);
        chk("br_lane", 32'(fl), 32'h2);
        chk("br_data", 32'(bus.cpuData_o), 32'h005A);
        do_req(1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000, bc, ec, fa, fd, fl, fw);
        chk("wr2_data", 32'(bus.cpuData_o), 32'h5AEF);

        // DMA word write/read; CPU read data untouched
        do_req(1'b1, 1'b1, 1'b0, 16'h0090, 16'hC0DE, bc, ec, fa, fd, fl, fw);
        chk("dw_busy", 32'(bc), 32'd5);
        do_req(1'b1, 1'b0, 1'b0, 16'h0090, 16'h0000, bc, ec, fa, fd, fl, fw);
        chk("dr_data",  32'(bus.dmaData_o), 32'hC0DE);
        chk("dr_cpu",   32'(bus.cpuData_o), 32'h5AEF);

        // Contention: four simultaneous rounds, grants alternate CPU, DMA
        for (int r = 0; r < 4; r++) begin
            dual(16'h0010 + 16'(r * 2), 16'h0080 + 16'(r * 2), cb, db);
            g0 = (grant_q.size() > 0) ? grant_q[0] : 16'hFFFF;
            g1 = (grant_q.size() > 1) ? grant_q[1] : 16'hFFFF;
            chk($sformatf("rr%0d_n", r),   32'(grant_q.size()), 32'd2);
            chk($sformatf("rr%0d_g0", r),  32'(g0), 32'(16'h0010 + 16'(r * 2)));
            chk($sformatf("rr%0d_g1", r),  32'(g1), 32'(16'h0080 + 16'(r * 2)));
            chk($sformatf("rr%0d_cb", r),  32'(cb), 32'd5);
            chk($sformatf("rr%0d_db", r),  32'(db), 32'd10);
        end

        // Pulse while busy is ignored
        grant_q.delete();
        bus.cpuRW_i = 1'b0; bus.cpuByte_i = 1'b0; bus.cpuAdr_i = 16'h0020; bus.cpuEn_i = 1'b1;
        @(posedge clk); #1;
        bus.cpuEn_i = 1'b0;
        @(posedge clk); #1;
        bus.cpuAdr_i = 16'h0030; bus.cpuEn_i = 1'b1;
        @(posedge clk); #1;
        bus.cpuEn_i = 1'b0;
        chk("ign_adr", 32'(bus.ramAdr_o), 32'h0020);
        for (int i = 0; i < 20 && bus.cpuBusy_o; i++) begin
            @(posedge clk); #1;
        end
        repeat (4) @(posedge clk);
        #1;
        chk("ign_busy",   32'(bus.cpuBusy_o), 32'd0);
        chk("ign_bursts", 32'(grant_q.size()), 32'd1);
        g0 = (grant_q.size() > 0) ? grant_q[0] : 16'hFFFF;
        chk("ign_g0", 32'(g0), 32'h0020);

        // Reset in second ACCESS cycle of a DMA write
        bus.dmaRW_i = 1'b1; bus.dmaByte_i = 1'b0; bus.dmaAdr_i = 16'h0060; bus.dmaData_i = 16'h1111;
        bus.dmaEn_i = 1'b1;
        @(posedge clk); #1;
        bus.dmaEn_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("ra_pre_en", 32'(bus.ramEn_o), 32'd1);
        arst = 1'b1;
        #1;
        chk("ra_en",   32'(bus.ramEn_o),   32'd0);
        chk("ra_wr",   32'(bus.ramWr_o),   32'd0);
        chk("ra_busy", 32'(bus.dmaBusy_o), 32'd0);
        @(posedge clk); #1;
        arst = 1'b0;
        @(posedge clk); #1;
        dual(16'h0050, 16'h0070, cb, db);
        g0 = (grant_q.size() > 0) ? grant_q[0] : 16'hFFFF;
        chk("ra_first", 32'(g0), 32'h0050);

        // WAIT=0 instance: DMA read
        bus0.dmaRW_i = 1'b0; bus0.dmaByte_i = 1'b0; bus0.dmaAdr_i = 16'h0002; bus0.dmaEn_i = 1'b1;
        @(posedge clk); #1;
        bus0.dmaEn_i = 1'b0;
        bc = 0; ec = 0;
        for (int i = 0; i < 20 && bus0.dmaBusy_o; i++) begin
            bc++;
            ec += int'(bus0.ramEn_o);
            @(posedge clk); #1;
        end
        chk("w0_busy", 32'(bc), 32'd3);
        chk("w0_en",   32'(ec), 32'd1);
        chk("w0_data", 32'(bus0.dmaData_o), 32'h1234);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/xm_mem_arbiter.md
Name: xm_mem_arbiter

Overview:
Shares the single multi-cycle data/instruction memory port between the CPU controller (fetch, load/store, PSW traffic) and a secondary requester (DMA/debug port). Accepts one-cycle request pulses, queues one pending request per requester, grants round-robin, and sequences a fixed-latency memory access with byte-lane handling. It drives the busy signal that the controller waits on during FETCH/DECODE.

Parameters:
WORD, 16, data width in bits (byte ops assume WORD = 16)
ADR, 16, address width in bits
WAIT, 2, extra memory wait cycles per access (0..15)

Ports:
clk_i  in  1  clock, all state updates on rising edge
arst_i  in  1  asynchronous active-high reset
cpuEn_i  in  1  CPU request pulse
cpuRW_i  in  1  CPU direction, 0 = read, 1 = write
cpuByte_i  in  1  CPU byte operation
cpuAdr_i  in  ADR  CPU byte address
cpuData_i  in  WORD  CPU write data
cpuData_o  out  WORD  CPU read data
cpuBusy_o  out  1  CPU request pending/in progress
dmaEn_i, dmaRW_i, dmaByte_i, dmaAdr_i, dmaData_i, dmaData_o, dmaBusy_o  same as CPU set, for the secondary requester
ramEn_o  out  1  memory access strobe
ramWr_o  out  1  memory write enable
ramLane_o  out  2  byte-lane enables, [0] = low byte, [1] = high byte
ramAdr_o  out  ADR  word address (bit 0 forced to 0)
ramData_o  out  WORD  memory write data
ramData_i  in  WORD  memory read data

Behaviour:
- Reset (async, arst_i high): state IDLE; pending flags cleared; lastGrant = DMA, so the CPU wins first; all outputs 0; data outputs 0.
- Accept: xEn_i is sampled only when xBusy_o = 0. On acceptance, the request (RW, byte, adr, data) is latched into that requester's slot and xBusy_o rises the next cycle. xEn_i while busy is ignored; no queueing beyond one slot.
- States:
  - IDLE: if any slot is pending, grant it. If both are pending, grant the one not equal to lastGrant. Then go to ACCESS with count = WAIT.
  - ACCESS: ramEn_o = 1 and the address, data, lane and write signals are stable every cycle. Count decrements. When count = 0, go to DONE.
  - DONE: ramEn_o = 0. For reads, ramData_i is captured into xData_o on the edge entering DONE. In DONE, the slot clears, xBusy_o drops, lastGrant is updated, and the state returns to IDLE.
- Latency: request accepted at edge N → ramEn_o high for WAIT+1 cycles starting after edge N+1 → xBusy_o low after edge N+3+WAIT. Uncontended WAIT=2 gives busy for 5 cycles.
- A request latched while DONE or IDLE is granted on the next IDLE evaluation. A new pulse from the just-completed requester is accepted in the first cycle busy is low.
- Lanes:
  - Word op: ramLane_o = 11, adr[0] ignored.
  - Byte write: lane = 01 if adr[0] = 0, else 10. The low byte is replicated on both halves of ramData_o.
  - Byte read: the selected byte is returned zero-extended in xData_o[7:0].
- xData_o holds its last read value until the next read completion for that requester. Writes leave xData_o unchanged.
- ramWr_o is 0 outside ACCESS.
- Reset mid-access: everything aborts immediately. The pending request is lost, and the requester must reissue it.
- No starvation: with both requesters saturating, grants strictly alternate.

Decomposition:
- Shared package xm_pkg:
  - arbiter state enum (IDLE, ACCESS, DONE)
  - requester ID constants REQ_CPU / REQ_DMA
  - RW encoding constants MEM_RD = 0, MEM_WR = 1
  - lane constants LANE_LO, LANE_HI, LANE_WORD
- Sub-module xm_mem_req_slot, instantiated twice: the accept/latch/pending register and busy generation for one requester.

Test Plan:
- CPU word write 0xBEEF to 0x0040, then read back (WAIT=2): ramLane_o=11, ramAdr_o=0x0040, cpuData_o=0xBEEF, cpuBusy_o high exactly 5 cycles each.
- CPU byte write 0x5A to 0x0041, then byte read of 0x0041: ramLane_o=10, ramData_o=0x5A5A, read returns 0x005A. A word read of 0x0040 returns 0x5AEF.
- CPU and DMA pulse en in the same cycle, four times back-to-back: grant order is CPU, DMA, CPU, DMA…, and neither busy exceeds 2×(WAIT+3) cycles.
- cpuEn_i pulsed again while cpuBusy_o = 1: the request is ignored, exactly one ramEn_o burst occurs, and the address is unchanged.
- arst_i asserted during the second ACCESS cycle of a DMA write: ramEn_o, ramWr_o and dmaBusy_o all go to 0 asynchronously. After release, the next simultaneous request grants the CPU first.
- With WAIT=0, a single read shows ramEn_o high for 1 cycle and busy for 3 cycles, and ramData_i=0x1234 is returned on dmaData_o.
